// File: rtl/counter_pkg.sv
// Shared constants for the rate/modulo counter family:
// step sizes, direction encodings and the default width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] STEP_SINGLE = 2'd1;
  localparam logic [1:0] STEP_DOUBLE = 2'd2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mod_step_unit.sv
// Combinational modulo-(limit+1) step of 1 or 2 in either
// direction, flagging when the step wraps the modulus.
module mod_step_unit
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic [1:0]       step,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] next,
  output logic             wrap
);

  logic [WIDTH-1:0] stp;
  logic [WIDTH:0]   modulus;
  logic [WIDTH:0]   sum;

  assign stp     = WIDTH'(step);
  assign modulus = {1'b0, limit} + (WIDTH+1)'(1);
  assign sum     = {1'b0, count} + {1'b0, stp};

  // Results always land below the modulus, so the final
  // values are exact in WIDTH bits; only the wrap test
  // needs the extra carry bit.
  always_comb begin
    wrap = 1'b0;
    next = count + stp;
    if (count > limit) begin
      wrap = 1'b1;
      next = (up == DIR_UP) ? '0 : limit;
    end else if (limit == '0) begin
      wrap = 1'b1;
      next = '0;
    end else if (up == DIR_UP) begin
      if (sum >= modulus) begin
        wrap = 1'b1;
        next = count + stp - limit - WIDTH'(1);
      end
    end else begin
      if (count < stp) begin
        wrap = 1'b1;
        next = count + limit + WIDTH'(1) - stp;
      end else begin
        next = count - stp;
      end
    end
  end

endmodule

// File: rtl/rate_mod_counter.sv
// Loadable up/down modulo counter with single/double step,
// registered terminal-count pulse and a compare match.
module rate_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter bit DBL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dbl,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             match
);

  // Initialisers give the FPGA power-up state.
  logic [WIDTH-1:0] count_q = '0;
  logic             tc_q    = 1'b0;
  logic [1:0]       step;
  logic [WIDTH-1:0] nxt;
  logic             wrap;

  assign step = (DBL_EN && dbl) ? STEP_DOUBLE : STEP_SINGLE;

  mod_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .count(count_q),
    .step (step),
    .up   (up),
    .limit(limit),
    .next (nxt),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else if (load) begin
      count_q <= load_val;
      tc_q    <= 1'b0;
    end else if (enable) begin
      count_q <= nxt;
      tc_q    <= wrap;
    end else begin
      tc_q    <= 1'b0;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign match = (count_q == cmp_val);

endmodule

// File: doc/rate_mod_counter.md
RATE_MOD_COUNTER -- requirements
Module: rate_mod_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter, limit, load and compare width in bits (2..16).
REQ-002 Parameter DBL_EN, default 1: 1 enables the dbl input; 0 ties the step to 1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  advance count by one step this cycle.
REQ-006 dbl  input  1  step = 2 when high (double-rate pixel counting), else step = 1.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  load count from load_val this cycle.
REQ-009 load_val  input  WIDTH  value taken on load.
REQ-010 limit  input  WIDTH  terminal value; counting is modulo M = limit+1.
REQ-011 cmp_val  input  WIDTH  compare value for match.
REQ-012 count  output  WIDTH  registered count.
REQ-013 tc  output  1  registered terminal-count pulse.
REQ-014 match  output  1  combinational: count == cmp_val.

Function
REQ-015 Priority per rising edge SHALL be reset > load > enable > hold.
REQ-016 load SHALL set count = load_val unreduced and tc = 0, regardless of enable.
REQ-017 With enable and up, next count SHALL be (count + step) mod M, computed in WIDTH+1 bits; M = 2^WIDTH when limit is all ones.
REQ-018 With enable and !up, next count SHALL be (count - step) mod M, computed in WIDTH+1 bits without underflow.
REQ-019 tc SHALL be 1 in the cycle following any enabled step whose result wrapped (up: count+step >= M; down: count < step), else 0; it is never held for more than one cycle per wrap.
REQ-020 If count > limit when an enabled step occurs (after load or a limit change), next count SHALL be 0 (up) or limit (down), with tc = 1.
REQ-021 limit = 0 SHALL hold count at 0 and pulse tc on every enabled step, for either step size.
REQ-022 When DBL_EN = 0, dbl SHALL be ignored.
REQ-023 With enable low and load low, count SHALL hold and tc SHALL be 0.
REQ-024 Latency: count and tc SHALL reflect an edge's inputs one clock later; match SHALL follow count combinationally with no added latency.
REQ-025 limit, up and dbl SHALL be sampled each cycle; changing them mid-count SHALL take effect on the next enabled step without glitching tc.

Reset
REQ-026 On reset high at a rising edge: count = 0 and tc = 0; match then evaluates (0 == cmp_val).
REQ-027 Reset asserted mid-count SHALL override simultaneous load and enable in the same cycle.
REQ-028 Registers SHALL also power up to 0 for FPGA targets.

Structure
REQ-029 Shared package counter_pkg SHALL hold STEP_SINGLE = 1 and STEP_DOUBLE = 2, the direction constants DIR_UP and DIR_DOWN, and the default WIDTH.
REQ-030 The modulo add/subtract path SHALL be one combinational sub-module, mod_step_unit (inputs count, step, up, limit; outputs next, wrap).
REQ-031 The top level SHALL hold only the count and tc registers, the priority logic and the match comparator.

Verification
REQ-032 WIDTH=8, limit=9, up, dbl=0, enable for 12 cycles from reset -> count 1..9,0,1,2; tc high only in the cycle count becomes 0.
REQ-033 limit=9, up, dbl=1, from 0, enable 6 cycles -> count 2,4,6,8,0,2; tc once, with the 0; then count=9 step -> 1 with tc.
REQ-034 Down, limit=255, dbl=1, load_val=1 then enable -> count 255, tc=1; next step 253, tc=0.
REQ-035 limit=5, load=1 with load_val=200 and enable=1 -> count 200, tc=0; next enabled up step -> 0, tc=1; cmp_val=200 -> match high only while count=200.
REQ-036 reset, load and enable all high at count=7 -> count 0, tc 0; limit=0 with dbl=1 enabled -> count stays 0, tc pulses every cycle.
